// File: rtl/req_encoder_4to2.sv
// Request-line event encoder: captures rising edges into a pending set and
// emits them as binary indices on a valid/ready stream. Optional ROUND_ROBIN_EN.
module req_encoder_4to2 #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] inpt,
   input  logic               enb,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [NUM_REQ-1:0] pend,
   output logic               drop
);

   // Handshake: an event transfers on a rising edge where out_vld & out_rdy;
   // while out_vld & ~out_rdy, out_idx/out_vld hold and pend only accumulates.
   logic [NUM_REQ-1:0] prev_q, prev_d;
   logic [NUM_REQ-1:0] pend_q, pend_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic               out_vld_q, out_vld_d;
   logic               drop_q, drop_d;
   logic [NUM_REQ-1:0] rise, clr_mask;
   logic [IDX_W-1:0]   sel;
   logic               load, any_pend;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0]   last_q, last_d;
   logic               found;

   // Rotating search starting just after the most recently loaded index.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int j;
         j = (int'(last_q) + k) % NUM_REQ;
         if (!found && pend_q[j]) begin
            sel   = IDX_W'(j);
            found = 1'b1;
         end
      end
   end
`else
   // Later iterations override earlier ones, so the highest pending index wins.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pend_q[i]) sel = IDX_W'(i);
      end
   end
`endif

   always_comb begin
      rise      = inpt & ~prev_q;
      load      = ~out_vld_q | out_rdy;
      any_pend  = |pend_q;
      clr_mask  = '0;
      if (load && any_pend) clr_mask[sel] = 1'b1;
      // Set is applied after clear so a re-rise on the bit being loaded stays pending.
      pend_d    = (pend_q & ~clr_mask) | (enb ? rise : '0);
      drop_d    = enb & |(rise & pend_q & ~clr_mask);
      prev_d    = inpt;
      out_vld_d = out_vld_q;
      out_idx_d = out_idx_q;
      if (load) begin
         out_vld_d = any_pend;
         if (any_pend) out_idx_d = sel;
      end
`ifdef ROUND_ROBIN_EN
      last_d = last_q;
      if (load && any_pend) last_d = sel;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q    <= '0;
         pend_q    <= '0;
         out_idx_q <= '0;
         out_vld_q <= 1'b0;
         drop_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_q    <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         prev_q    <= prev_d;
         pend_q    <= pend_d;
         out_idx_q <= out_idx_d;
         out_vld_q <= out_vld_d;
         drop_q    <= drop_d;
`ifdef ROUND_ROBIN_EN
         last_q    <= last_d;
`endif
      end
   end

   assign out_idx = out_idx_q;
   assign out_vld = out_vld_q;
   assign pend    = pend_q;
   assign drop    = drop_q;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Bench for req_encoder_4to2: directed scenarios plus random traffic, each
// cycle compared against an event-set reference model.
module tb_req_encoder_4to2;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  inpt = '0;
   logic          enb = 1'b0;
   logic          out_rdy = 1'b0;
   logic [IW-1:0] out_idx;
   logic          out_vld;
   logic [N-1:0]  pend;
   logic          drop;

   int checks = 0;
   int failures = 0;

   bit m_prev[N];
   bit m_pend[N];
   bit m_vld, m_drop;
   int m_idx, m_last;

`ifdef ROUND_ROBIN_EN
   int t2_exp[3] = '{0, 1, 3};
   int t6_exp[2] = '{1, 2};
`else
   int t2_exp[3] = '{3, 1, 0};
   int t6_exp[2] = '{2, 1};
`endif

   req_encoder_4to2 #(.NUM_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .inpt(inpt), .enb(enb),
      .out_idx(out_idx), .out_vld(out_vld), .out_rdy(out_rdy),
      .pend(pend), .drop(drop)
   );

   always #5 clk = ~clk;

   function automatic int pick();
`ifdef ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++)
         if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
`else
      for (int i = N - 1; i >= 0; i--)
         if (m_pend[i]) return i;
`endif
      return -1;
   endfunction

   function automatic logic [31:0] m_pend_vec();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_step();
      bit rise[N];
      int c;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
         end
         m_vld  = 1'b0;
         m_idx  = 0;
         m_drop = 1'b0;
         m_last = N - 1;
      end else begin
         for (int i = 0; i < N; i++) rise[i] = inpt[i] && !m_prev[i];
         if (!m_vld || out_rdy) begin
            c = pick();
            if (c >= 0) begin
               m_vld     = 1'b1;
               m_idx     = c;
               m_pend[c] = 1'b0;
               m_last    = c;
            end else begin
               m_vld = 1'b0;
            end
         end
         m_drop = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (enb && rise[i]) begin
               if (m_pend[i]) m_drop = 1'b1;
               m_pend[i] = 1'b1;
            end
         end
         for (int i = 0; i < N; i++) m_prev[i] = inpt[i];
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("m_pend", 32'(pend), m_pend_vec());
      check("m_vld", 32'(out_vld), 32'(m_vld));
      check("m_drop", 32'(drop), 32'(m_drop));
      check("m_idx", 32'(out_idx), 32'(m_idx));
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      cycle();
      cycle();
      check("rst_vld", 32'(out_vld), 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_drop", 32'(drop), 32'd0);
      rst_n = 1'b1; enb = 1'b1; out_rdy = 1'b1;
      cycle();

      // T1: single rise, two-edge latency
      inpt = 4'b0100;
      cycle();
      check("t1_no_early_vld", 32'(out_vld), 32'd0);
      check("t1_pend", 32'(pend), 32'h4);
      cycle();
      check("t1_vld", 32'(out_vld), 32'd1);
      check("t1_idx", 32'(out_idx), 32'd2);
      check("t1_drop", 32'(drop), 32'd0);
      inpt = 4'b0000;
      cycle();
      check("t1_idle", 32'(out_vld), 32'd0);

      // T2: three simultaneous rises from a fresh reset
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      inpt = 4'b1011;
      cycle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("t2_vld", 32'(out_vld), 32'd1);
         check("t2_idx", 32'(out_idx), 32'(t2_exp[k]));
      end
      cycle();
      check("t2_done", 32'(out_vld), 32'd0);
      inpt = 4'b0000;
      cycle();

      // T3: stalled output holds, later event waits in pend
      out_rdy = 1'b0;
      inpt = 4'b0001;
      cycle();
      cycle();
      inpt = 4'b0101;
      cycle();
      cycle();
      check("t3_hold_vld", 32'(out_vld), 32'd1);
      check("t3_hold_idx", 32'(out_idx), 32'd0);
      check("t3_pend", 32'(pend), 32'h4);
      out_rdy = 1'b1;
      cycle();
      check("t3_next_idx", 32'(out_idx), 32'd2);
      cycle();
      check("t3_empty", 32'(out_vld), 32'd0);
      inpt = 4'b0000;
      cycle();

      // T4: repeated rise on a pending bit merges and pulses drop
      out_rdy = 1'b0;
      inpt = 4'b1000;
      cycle();
      cycle();
      inpt = 4'b1010;
      cycle();
      inpt = 4'b1000;
      cycle();
      inpt = 4'b1010;
      cycle();
      check("t4_drop", 32'(drop), 32'd1);
      check("t4_pend", 32'(pend), 32'h2);
      cycle();
      check("t4_drop_pulse", 32'(drop), 32'd0);
      out_rdy = 1'b1;
      cycle();
      check("t4_idx", 32'(out_idx), 32'd1);
      check("t4_vld", 32'(out_vld), 32'd1);
      cycle();
      check("t4_single", 32'(out_vld), 32'd0);
      inpt = 4'b0000;
      cycle();

      // T5: capture disabled, then enabled with lines already high
      enb = 1'b0;
      inpt = 4'b1111;
      repeat (3) cycle();
      check("t5_pend", 32'(pend), 32'd0);
      check("t5_vld", 32'(out_vld), 32'd0);
      enb = 1'b1;
      repeat (2) cycle();
      check("t5_no_edge_pend", 32'(pend), 32'd0);
      check("t5_no_edge_vld", 32'(out_vld), 32'd0);
      inpt = 4'b0000;
      cycle();

      // T6: reset mid-transfer, lines high afterwards re-trigger
      out_rdy = 1'b0;
      inpt = 4'b1000;
      cycle();
      cycle();
      inpt = 4'b0110;
      cycle();
      check("t6_pre_pend", 32'(pend), 32'h6);
      check("t6_pre_vld", 32'(out_vld), 32'd1);
      rst_n = 1'b0;
      cycle();
      check("t6_rst_pend", 32'(pend), 32'd0);
      check("t6_rst_vld", 32'(out_vld), 32'd0);
      check("t6_rst_drop", 32'(drop), 32'd0);
      rst_n = 1'b1;
      out_rdy = 1'b1;
      cycle();
      cycle();
      check("t6_ev0", 32'(out_idx), 32'(t6_exp[0]));
      cycle();
      check("t6_ev1", 32'(out_idx), 32'(t6_exp[1]));
      cycle();
      check("t6_end", 32'(out_vld), 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 500; n++) begin
         inpt    = 4'($urandom_range(0, 15));
         enb     = ($urandom_range(0, 9) != 0);
         out_rdy = ($urandom_range(0, 3) != 0);
         rst_n   = ($urandom_range(0, 63) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
